// File: rtl/postproc_pkg.sv
// Shared constants and types for the FFT/IFFT post-processing stage.
// Symbol sizes up to 2048 samples; the ping-pong buffer holds one such symbol per bank.
package postproc_pkg;

  localparam int FFT_NUM_NBIT  = 12;
  localparam int BUF_ADDR_NBIT = 11;

  localparam int CP_EXT_SHIFT = 2;
  localparam int CP_NOR_MUL   = 9;
  localparam int CP_NOR_SHIFT = 7;
  localparam int CP_FST_MUL   = 5;
  localparam int CP_FST_SHIFT = 6;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_CP   = 2'd1,
    RD_BODY = 2'd2
  } rd_state_e;

  // Per-bank symbol descriptor captured at start of packet.
  typedef struct packed {
    logic [FFT_NUM_NBIT-1:0] n;
    logic [FFT_NUM_NBIT-1:0] cp;
    logic                    fst;
  } sym_info_t;

endpackage

// File: rtl/postproc_cp_len.sv
// Cyclic-prefix length from symbol size, CP type and first-symbol-of-slot flag.
// Purely combinational; products are formed with 4 guard bits, then truncated.
module postproc_cp_len
  import postproc_pkg::*;
(
  input  logic [FFT_NUM_NBIT-1:0] n_i,
  input  logic                    cp_type_i,
  input  logic                    fst_i,
  output logic [FFT_NUM_NBIT-1:0] cp_o
);

  localparam int W = FFT_NUM_NBIT + 4;

  logic [W-1:0] n_w;

  assign n_w = W'(n_i);

  always_comb begin
    cp_o = FFT_NUM_NBIT'(n_w >> CP_EXT_SHIFT);
    if (!cp_type_i) begin
      if (fst_i) begin
        cp_o = FFT_NUM_NBIT'((n_w * W'(CP_FST_MUL)) >> CP_FST_SHIFT);
      end else begin
        cp_o = FFT_NUM_NBIT'((n_w * W'(CP_NOR_MUL)) >> CP_NOR_SHIFT);
      end
    end
  end

endmodule

// File: rtl/postproc.sv
// FFT core post-processing: FFT mode is a 1-cycle registered pass-through; IFFT mode buffers each
// symbol in a ping-pong RAM and replays it CP-first at one sample per CLK_FS_RATIO clocks (2-cycle read latency, no backpressure; ovf on overrun).
module postproc
  import postproc_pkg::*;
#(
  parameter int DATA_NBIT    = 15,
  parameter int CLK_FS_RATIO = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fft_type,
  input  logic                    cp_type,
  input  logic                    din_sop,
  input  logic                    din_valid,
  input  logic [DATA_NBIT-1:0]    din_real,
  input  logic [DATA_NBIT-1:0]    din_imag,
  input  logic                    din_eop,
  input  logic [FFT_NUM_NBIT-1:0] din_fft_num,
  input  logic                    din_fst_cp,
  output logic [DATA_NBIT-1:0]    dout_i,
  output logic [DATA_NBIT-1:0]    dout_q,
  output logic                    dout_h,
  output logic                    dout_s,
  output logic                    dout_v,
  output logic                    ovf
);

  localparam int CNT_W  = (CLK_FS_RATIO > 1) ? $clog2(CLK_FS_RATIO) : 1;
  localparam int RAM_AW = BUF_ADDR_NBIT + 1;
  localparam int RAM_DW = 2 * DATA_NBIT;

  logic [RAM_DW-1:0] mem [2**RAM_AW];
  logic [RAM_DW-1:0] rdata_q;

  // write side
  logic                     wr_bank_q, wr_bank_d;
  logic                     wr_act_q, wr_act_d;
  logic [BUF_ADDR_NBIT-1:0] wr_cnt_q, wr_cnt_d, waddr;
  logic [1:0]               full_q, full_d;
  sym_info_t                info_q [2];
  logic [FFT_NUM_NBIT-1:0]  sop_cp, cur_n;
  logic                     sop_v, wr_start, wr_cont, wr_drop, we, wr_last;
  logic                     ovf_q;

  // read side
  rd_state_e                state_q, state_d;
  sym_info_t                rd_info;
  logic                     rd_bank_q, rd_bank_d;
  logic [BUF_ADDR_NBIT-1:0] raddr_q, raddr_d, cp_start;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     strobe, rd_en, rd_first, rd_done, rd_last;
  logic                     rd_vld_q, rd_h_q, rd_s_q;

  logic [DATA_NBIT-1:0]     dout_i_q, dout_q_q;
  logic                     dout_h_q, dout_s_q, dout_v_q;

  postproc_cp_len u_cp_len (
    .n_i       (din_fft_num),
    .cp_type_i (cp_type),
    .fst_i     (din_fst_cp),
    .cp_o      (sop_cp)
  );

  // Write side: a sop into a still-occupied bank drops the whole packet.
  always_comb begin
    sop_v    = fft_type & din_valid & din_sop;
    wr_start = sop_v & ~full_q[wr_bank_q];
    wr_drop  = sop_v &  full_q[wr_bank_q];
    wr_cont  = fft_type & din_valid & ~din_sop & wr_act_q;
    we       = wr_start | wr_cont;
    waddr    = wr_start ? '0 : wr_cnt_q;
    cur_n    = wr_start ? din_fft_num : info_q[wr_bank_q].n;
    wr_last  = we & (din_eop | (FFT_NUM_NBIT'(waddr) == cur_n - 1'b1));

    wr_cnt_d  = we ? waddr + 1'b1 : wr_cnt_q;
    wr_bank_d = wr_bank_q ^ wr_last;
    wr_act_d  = wr_act_q;
    if (we) begin
      wr_act_d = ~wr_last;
    end else if (wr_drop) begin
      wr_act_d = 1'b0;
    end

    full_d = full_q;
    if (rd_done) full_d[rd_bank_q] = 1'b0;
    if (wr_last) full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank_q <= 1'b0;
      wr_act_q  <= 1'b0;
      wr_cnt_q  <= '0;
      full_q    <= '0;
      ovf_q     <= 1'b0;
      info_q[0] <= '0;
      info_q[1] <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_act_q  <= wr_act_d;
      wr_cnt_q  <= wr_cnt_d;
      full_q    <= full_d;
      ovf_q     <= wr_drop;
      if (wr_start) begin
        info_q[wr_bank_q] <= '{n: din_fft_num, cp: sop_cp, fst: din_fst_cp};
      end
    end
  end

  // Read FSM
  always_comb begin
    rd_info  = info_q[rd_bank_q];
    cp_start = BUF_ADDR_NBIT'(rd_info.n - rd_info.cp);
    rd_last  = (FFT_NUM_NBIT'(raddr_q) == rd_info.n - 1'b1);
    strobe   = (state_q != RD_IDLE) && (cnt_q == '0);

    state_d   = state_q;
    raddr_d   = raddr_q;
    rd_bank_d = rd_bank_q;
    rd_en     = 1'b0;
    rd_first  = 1'b0;
    rd_done   = 1'b0;

    case (state_q)
      RD_IDLE: begin
        if (fft_type && full_q[rd_bank_q]) begin
          state_d = RD_CP;
          raddr_d = cp_start;
        end
      end
      RD_CP: begin
        if (strobe) begin
          rd_en    = 1'b1;
          rd_first = (raddr_q == cp_start);
          if (rd_last) begin
            state_d = RD_BODY;
            raddr_d = '0;
          end else begin
            raddr_d = raddr_q + 1'b1;
          end
        end
      end
      RD_BODY: begin
        if (strobe) begin
          rd_en = 1'b1;
          if (rd_last) begin
            rd_done   = 1'b1;
            rd_bank_d = ~rd_bank_q;
            state_d   = RD_IDLE;
            raddr_d   = '0;
          end else begin
            raddr_d = raddr_q + 1'b1;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase

    // The sample period in flight when a symbol ends is allowed to finish, so a queued
    // symbol keeps the exact sample cadence; from true idle the count is already 0.
    if ((state_q == RD_IDLE) && (cnt_q == '0)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(CLK_FS_RATIO - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RD_IDLE;
      rd_bank_q <= 1'b0;
      raddr_q   <= '0;
      cnt_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_h_q    <= 1'b0;
      rd_s_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      raddr_q   <= raddr_d;
      cnt_q     <= cnt_d;
      rd_vld_q  <= rd_en;
      rd_h_q    <= rd_first;
      rd_s_q    <= rd_first & rd_info.fst;
    end
  end

  // Simple dual-port RAM; a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wr_bank_q, waddr}] <= {din_real, din_imag};
    end
    if (rd_en) begin
      rdata_q <= mem[{rd_bank_q, raddr_q}];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_i_q <= '0;
      dout_q_q <= '0;
      dout_h_q <= 1'b0;
      dout_s_q <= 1'b0;
      dout_v_q <= 1'b0;
    end else if (!fft_type) begin
      dout_i_q <= din_real;
      dout_q_q <= din_imag;
      dout_v_q <= din_valid;
      dout_h_q <= din_sop & din_valid;
      dout_s_q <= din_sop & din_valid & din_fst_cp;
    end else begin
      dout_v_q <= rd_vld_q;
      dout_h_q <= rd_h_q;
      dout_s_q <= rd_s_q;
      if (rd_vld_q) begin
        dout_i_q <= rdata_q[RAM_DW-1 -: DATA_NBIT];
        dout_q_q <= rdata_q[DATA_NBIT-1:0];
      end
    end
  end

  assign dout_i = dout_i_q;
  assign dout_q = dout_q_q;
  assign dout_h = dout_h_q;
  assign dout_s = dout_s_q;
  assign dout_v = dout_v_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_postproc.sv
// Scoreboard bench for postproc: stimulus pushes expected samples, a negedge monitor pops and compares.
module tb_postproc;
  import postproc_pkg::*;

  localparam int DW = 15;
  localparam int R  = 5;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    fft_type = 1'b0;
  logic                    cp_type = 1'b0;
  logic                    din_sop = 1'b0;
  logic                    din_valid = 1'b0;
  logic                    din_eop = 1'b0;
  logic                    din_fst_cp = 1'b0;
  logic [DW-1:0]           din_real = '0;
  logic [DW-1:0]           din_imag = '0;
  logic [FFT_NUM_NBIT-1:0] din_fft_num = '0;
  logic [DW-1:0]           dout_i, dout_q;
  logic                    dout_h, dout_s, dout_v, ovf;

  postproc #(.DATA_NBIT(DW), .CLK_FS_RATIO(R)) dut (
    .clk         (clk),
    .reset       (reset),
    .fft_type    (fft_type),
    .cp_type     (cp_type),
    .din_sop     (din_sop),
    .din_valid   (din_valid),
    .din_real    (din_real),
    .din_imag    (din_imag),
    .din_eop     (din_eop),
    .din_fft_num (din_fft_num),
    .din_fst_cp  (din_fst_cp),
    .dout_i      (dout_i),
    .dout_q      (dout_q),
    .dout_h      (dout_h),
    .dout_s      (dout_s),
    .dout_v      (dout_v),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int i;
    int q;
    bit h;
    bit s;
    int gap;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   vcnt = 0;
  int   last_v = -1;
  int   h_prev = -1;
  int   h_last = -1;
  int   ovf_cnt = 0;
  int   ovf_cyc = -1;
  int   sop_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int dr(int k, int off);
    return (k + off) & 32'h7fff;
  endfunction

  function automatic int di(int k, int off);
    return (3 * k + off + 77) & 32'h7fff;
  endfunction

  // Hand table of CP lengths: extended / normal-first / normal-other.
  function automatic int cp_ref(int n, bit ext, bit fst);
    case (n)
      2048:    return ext ? 512 : (fst ? 160 : 144);
      1536:    return ext ? 384 : (fst ? 120 : 108);
      1024:    return ext ? 256 : (fst ? 80 : 72);
      default: return ext ? 128 : (fst ? 40 : 36);
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset && mon_en) begin
      if (ovf) begin
        ovf_cnt++;
        ovf_cyc = cyc;
      end
      if (dout_v) begin
        vcnt++;
        if (dout_h) begin
          h_prev = h_last;
          h_last = cyc;
        end
        if (sb.size() == 0) begin
          chk("unexpected_v", int'(dout_v), 0);
        end else begin
          e = sb.pop_front();
          chk("dout_i", int'(dout_i), e.i);
          chk("dout_q", int'(dout_q), e.q);
          chk("dout_h", int'(dout_h), int'(e.h));
          chk("dout_s", int'(dout_s), int'(e.s));
          if (e.gap != 0) chk("v_spacing", cyc - last_v, e.gap);
        end
        last_v = cyc;
      end else begin
        chk("hs_without_v", int'({dout_h, dout_s}), 0);
      end
    end
  end

  task automatic idle_in();
    @(posedge clk); #1;
    din_valid = 1'b0;
    din_sop   = 1'b0;
    din_eop   = 1'b0;
  endtask

  task automatic send_fft(int n, bit fst);
    for (int k = 0; k < n; k++) begin
      sb.push_back('{dr(k, 0), di(k, 0), k == 0, (k == 0) && fst, (k == 0) ? 0 : 1});
      @(posedge clk); #1;
      din_valid   = 1'b1;
      din_sop     = (k == 0);
      din_eop     = (k == n - 1);
      din_real    = DW'(dr(k, 0));
      din_imag    = DW'(di(k, 0));
      din_fft_num = FFT_NUM_NBIT'(n);
      din_fst_cp  = (k == 0) ? fst : 1'b1;
    end
  endtask

  task automatic send_sym(int n, bit ext, bit fst, int off, bit push, int first_gap);
    int cp;
    cp = cp_ref(n, ext, fst);
    if (push) begin
      for (int j = 0; j < cp; j++)
        sb.push_back('{dr(n - cp + j, off), di(n - cp + j, off), j == 0, (j == 0) && fst,
                       (j == 0) ? first_gap : R});
      for (int k = 0; k < n; k++)
        sb.push_back('{dr(k, off), di(k, off), 1'b0, 1'b0, R});
    end
    cp_type = ext;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      din_valid   = 1'b1;
      din_sop     = (k == 0);
      din_eop     = (k == n - 1);
      din_real    = DW'(dr(k, off));
      din_imag    = DW'(di(k, off));
      din_fft_num = (k == 0) ? FFT_NUM_NBIT'(n) : '0;
      din_fst_cp  = (k == 0) ? fst : ~fst;
      if (k == 0) sop_cyc = cyc;
    end
  endtask

  task automatic drain(string name, int budget);
    int t;
    t = 0;
    while (sb.size() != 0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    chk({name, "_left_in_queue"}, sb.size(), 0);
    repeat (2 * R + 4) @(posedge clk);
  endtask

  task automatic check_zero(string name);
    chk({name, "_v"}, int'(dout_v), 0);
    chk({name, "_h"}, int'(dout_h), 0);
    chk({name, "_s"}, int'(dout_s), 0);
    chk({name, "_i"}, int'(dout_i), 0);
    chk({name, "_q"}, int'(dout_q), 0);
    chk({name, "_ovf"}, int'(ovf), 0);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, o0, s3;

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk) reset = 1'b1;
    mon_en = 1'b1;

    // FFT pass-through
    fft_type = 1'b0;
    v0 = vcnt;
    send_fft(2048, 1'b1);
    idle_in();
    drain("fft", 200);
    chk("fft_v_count", vcnt - v0, 2048);

    // IFFT 2048 normal, first symbol of slot, plain ramp
    fft_type = 1'b1;
    v0 = vcnt;
    send_sym(2048, 1'b0, 1'b1, 0, 1'b1, 0);
    idle_in();
    drain("ifft2048", 13000);
    chk("ifft2048_v_count", vcnt - v0, 2208);

    // IFFT 512 extended, preceded by a stray valid outside any packet
    v0 = vcnt;
    @(posedge clk); #1;
    din_valid = 1'b1;
    din_real  = DW'(12345);
    idle_in();
    send_sym(512, 1'b1, 1'b0, 300, 1'b1, 0);
    idle_in();
    drain("ifft512ext", 4000);
    chk("ifft512ext_v_count", vcnt - v0, 640);

    // Two 1536 symbols back to back
    v0 = vcnt;
    o0 = ovf_cnt;
    send_sym(1536, 1'b0, 1'b0, 10, 1'b1, 0);
    send_sym(1536, 1'b0, 1'b0, 700, 1'b1, R);
    idle_in();
    drain("b2b1536", 18000);
    chk("b2b1536_v_count", vcnt - v0, 3288);
    chk("b2b1536_h_gap", h_last - h_prev, 1644 * R);
    chk("b2b1536_ovf", ovf_cnt - o0, 0);

    // Three 1024 symbols: third finds both banks busy
    v0 = vcnt;
    o0 = ovf_cnt;
    send_sym(1024, 1'b0, 1'b1, 20, 1'b1, 0);
    send_sym(1024, 1'b0, 1'b1, 900, 1'b1, R);
    send_sym(1024, 1'b0, 1'b1, 1500, 1'b0, 0);
    s3 = sop_cyc;
    idle_in();
    drain("drop1024", 13000);
    chk("drop1024_v_count", vcnt - v0, 2208);
    chk("drop1024_ovf_count", ovf_cnt - o0, 1);
    chk("drop1024_ovf_cycle", ovf_cyc, s3 + 1);

    // Reset in the middle of BODY playout, then a fresh 512 symbol
    mon_en = 1'b0;
    send_sym(512, 1'b0, 1'b0, 40, 1'b0, 0);
    idle_in();
    repeat (96 * R) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    check_zero("midreset");
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    sb.delete();
    mon_en = 1'b1;
    v0 = vcnt;
    o0 = ovf_cnt;
    send_sym(512, 1'b0, 1'b0, 60, 1'b1, 0);
    idle_in();
    drain("post_reset512", 3500);
    chk("post_reset512_v_count", vcnt - v0, 548);
    chk("post_reset512_ovf", ovf_cnt - o0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
